mem_bank_stream_addr_gen: RTL



---
 rtl/mem_bank_stream_addr_gen.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/mem_bank_stream_addr_gen.sv
// Strided/linear address sequencer for one operand buffer bank with pass replay.
// Optional bound check: define MEM_BANK_ADDR_BOUND_CHECK_EN to build addr_err_o logic.
module mem_bank_stream_addr_gen #(
   parameter int ARRAY_WIDTH          = 4,
   parameter int BUS_WIDTH_BYTES      = 32,
   parameter int DATA_WIDTH_BYTES     = 1,
   parameter int BUFFER_ADDRESS_WIDTH = 10
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            start_i,
   input  logic                            mode_i,
   input  logic [15:0]                     n,
   input  logic [15:0]                     p,
   input  logic [7:0]                      reps_i,
   input  logic                            valid_i,
   output logic [BUFFER_ADDRESS_WIDTH-1:0] addr_o,
   output logic                            burst_last_o,
   output logic                            busy_o,
   output logic                            done_o,
   output logic [15:0]                     global_counts,
   input  logic                            clear,
   output logic                            addr_err_o
);
   localparam int BURST = BUS_WIDTH_BYTES / DATA_WIDTH_BYTES / ARRAY_WIDTH;
   localparam int BW    = $clog2(BURST);

   typedef enum logic {IDLE, RUN} state_t;

   state_t        state, state_n;
   logic          mode_q, mode_n;
   logic [15:0]   n_q, n_n, p_q, p_n, i_q, i_n, j_q, j_n;
   logic [7:0]    reps_q, reps_n, pass_q, pass_n;
   logic [31:0]   lin, lin_n, col_base, col_base_n;
   logic [BW-1:0] bcnt, bcnt_n;
   logic          done_n, last_n, burst_last_n, beat, last_elem;

   assign beat      = valid_i & (state == RUN);
   assign last_elem = (i_q == n_q - 16'd1) && (j_q == p_q - 16'd1);

   always_comb begin
      state_n    = state;
      mode_n     = mode_q;
      n_n        = n_q;
      p_n        = p_q;
      reps_n     = reps_q;
      i_n        = i_q;
      j_n        = j_q;
      pass_n     = pass_q;
      lin_n      = lin;
      col_base_n = col_base;
      bcnt_n     = bcnt;
      done_n     = 1'b0;
      if (start_i) begin
         // start overrides any in-flight sequence and any same-cycle beat
         mode_n     = mode_i;
         n_n        = n;
         p_n        = p;
         reps_n     = reps_i;
         i_n        = '0;
         j_n        = '0;
         pass_n     = '0;
         lin_n      = '0;
         col_base_n = '0;
         bcnt_n     = '0;
         if (n == 16'd0 || p == 16'd0 || reps_i == 8'd0) begin
            state_n = IDLE;
            done_n  = 1'b1;
         end else begin
            state_n = RUN;
         end
      end else if (beat) begin
         bcnt_n = bcnt + BW'(1);
         if (last_elem) begin
            i_n        = '0;
            j_n        = '0;
            lin_n      = '0;
            col_base_n = '0;
            bcnt_n     = '0;
            if (pass_q < reps_q - 8'd1) begin
               pass_n = pass_q + 8'd1;
            end else begin
               pass_n  = '0;
               state_n = IDLE;
               done_n  = 1'b1;
            end
         end else if (mode_q) begin
            lin_n = lin + 32'd1;
            if (j_q == p_q - 16'd1) begin
               j_n = '0;
               i_n = i_q + 16'd1;
            end else begin
               j_n = j_q + 16'd1;
            end
         end else begin
            if (i_q == n_q - 16'd1) begin
               lin_n      = col_base + 32'd1;
               col_base_n = col_base + 32'd1;
               i_n        = '0;
               j_n        = j_q + 16'd1;
            end else begin
               lin_n = lin + 32'(p_q);
               i_n   = i_q + 16'd1;
            end
         end
      end
      last_n       = (i_n == n_n - 16'd1) && (j_n == p_n - 16'd1);
      burst_last_n = (state_n == RUN) && ((bcnt_n == BW'(BURST - 1)) || last_n);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         mode_q       <= 1'b0;
         n_q          <= '0;
         p_q          <= '0;
         reps_q       <= '0;
         i_q          <= '0;
         j_q          <= '0;
         pass_q       <= '0;
         lin          <= '0;
         col_base     <= '0;
         bcnt         <= '0;
         done_o       <= 1'b0;
         burst_last_o <= 1'b0;
      end else begin
         state        <= state_n;
         mode_q       <= mode_n;
         n_q          <= n_n;
         p_q          <= p_n;
         reps_q       <= reps_n;
         i_q          <= i_n;
         j_q          <= j_n;
         pass_q       <= pass_n;
         lin          <= lin_n;
         col_base     <= col_base_n;
         bcnt         <= bcnt_n;
         done_o       <= done_n;
         burst_last_o <= burst_last_n;
      end
   end

   always_ff @(posedge clk) begin
      if (reset)                 global_counts <= '0;
      else if (clear | start_i)  global_counts <= '0;
      else if (beat && global_counts != 16'hFFFF)
         global_counts <= global_counts + 16'd1;
   end

`ifdef MEM_BANK_ADDR_BOUND_CHECK_EN
   always_ff @(posedge clk) begin
      if (reset)        addr_err_o <= 1'b0;
      else if (start_i) addr_err_o <= 1'b0;
      else if (beat && (|lin[31:BUFFER_ADDRESS_WIDTH])) addr_err_o <= 1'b1;
   end
`else
   assign addr_err_o = 1'b0;
`endif

   assign addr_o = lin[BUFFER_ADDRESS_WIDTH-1:0];
   assign busy_o = (state == RUN);
endmodule
